// File: rtl/time_display_mux.sv
// time_display_mux: scans BCD time digits onto an 8-digit common-anode 7-segment display,
// snapshotting inputs once per frame, with edit-mode blink, 12h leading-zero blanking and PM dot.
module time_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fmt,
  input  logic       ampm,
  input  logic       edit,
  input  logic [3:0] hrL,
  input  logic [3:0] hrR,
  input  logic [3:0] mL,
  input  logic [3:0] mR,
  input  logic [3:0] sL,
  input  logic [3:0] sR,
  input  logic [3:0] milL,
  input  logic [3:0] milM,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          phase_q, phase_d;
  logic          fmt_q, ampm_q, edit_q;
  logic [31:0]   dig_q;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d, seg_raw;
  logic          dp_q, dp_d, frame_q;
  logic          snap, rwrap, bwrap, blank;
  logic [3:0]    digit;
  always_comb begin
    snap    = idx_q == 3'd0 && rcnt_q == '0;
    rwrap   = rcnt_q == RW'(REFRESH_DIV - 1);
    bwrap   = bcnt_q == BW'(BLINK_DIV - 1);
    rcnt_d  = rwrap ? '0 : rcnt_q + 1'b1;
    idx_d   = rwrap ? idx_q + 3'd1 : idx_q;
    bcnt_d  = (!edit_q || bwrap) ? '0 : bcnt_q + 1'b1;
    phase_d = edit_q & (phase_q ^ bwrap);
    digit   = dig_q[{idx_q, 2'b00} +: 4];
    // hours/minutes share the upper four slots, so idx_q[2] selects the editable digits
    blank   = (idx_q == 3'd7 && fmt_q && dig_q[31:28] == 4'd0) || (idx_q[2] && edit_q && phase_q);
    case (digit)
      4'd0:    seg_raw = 7'h40;
      4'd1:    seg_raw = 7'h79;
      4'd2:    seg_raw = 7'h24;
      4'd3:    seg_raw = 7'h30;
      4'd4:    seg_raw = 7'h19;
      4'd5:    seg_raw = 7'h12;
      4'd6:    seg_raw = 7'h02;
      4'd7:    seg_raw = 7'h78;
      4'd8:    seg_raw = 7'h00;
      4'd9:    seg_raw = 7'h10;
      default: seg_raw = 7'h3F;
    endcase
    seg_d = blank ? 7'h7F : seg_raw;
    an_d  = blank ? 8'hFF : ~(8'd1 << idx_q);
    dp_d  = blank | ~((!idx_q[0] && idx_q != 3'd0) || (idx_q == 3'd0 && fmt_q && ampm_q));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q  <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      fmt_q   <= 1'b0;
      ampm_q  <= 1'b0;
      edit_q  <= 1'b0;
      dig_q   <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= snap;
      if (snap) begin
        fmt_q  <= fmt;
        ampm_q <= ampm;
        edit_q <= edit;
        dig_q  <= {hrL, hrR, mL, mR, sL, sR, milL, milM};
      end
    end
  end
  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;
endmodule
